// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared defaults and helpers for the pipelined carry adder
package adder_pkg;

   localparam int DEFAULT_WIDTH  = 16;
   localparam int DEFAULT_STAGES = 4;

   // Two's-complement overflow: operands agree in sign, result does not.
   function automatic logic signed_overflow(input logic a_msb, input logic b_msb,
                                            input logic sum_msb);
      return (a_msb == b_msb) && (sum_msb != a_msb);
   endfunction

endpackage

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - combinational CHUNK-bit ripple-carry slice
module adder_slice #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);

   logic [CHUNK:0] carry;

   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = cin;
      for (int i = 0; i < CHUNK; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry[i];
         carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
      cout = carry[CHUNK];
   end

endmodule

// File: rtl/pipelined_carry_adder.sv
// rtl/pipelined_carry_adder.sv - WIDTH-bit add/subtract split into STAGES registered ripple slices
module pipelined_carry_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int STAGES = DEFAULT_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CHUNK = WIDTH / STAGES;

   if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
      $error("pipelined_carry_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
   end

   logic             en;
   logic [WIDTH-1:0] b_eff;

   // Operands shift right by CHUNK per stage so each slice always reads the low
   // CHUNK bits; finished sum slices shift in from the top and land aligned at the end.
   logic             v_q      [STAGES];
   logic             c_q      [STAGES];
   logic [WIDTH-1:0] a_q      [STAGES];
   logic [WIDTH-1:0] b_q      [STAGES];
   logic [WIDTH-1:0] s_q      [STAGES];
   logic             am_q     [STAGES];
   logic             bm_q     [STAGES];
   logic [CHUNK-1:0] sl_sum   [STAGES];
   logic             sl_cout  [STAGES];
   logic [WIDTH-1:0] sum_full [STAGES];

   assign en       = !out_valid || out_ready;
   assign in_ready = en;
   assign b_eff    = sub ? ~b : b;

   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      adder_slice #(.CHUNK(CHUNK)) u_slice (
         .a    (a_q[k][CHUNK-1:0]),
         .b    (b_q[k][CHUNK-1:0]),
         .cin  (c_q[k]),
         .sum  (sl_sum[k]),
         .cout (sl_cout[k])
      );
      assign sum_full[k] = (s_q[k] >> CHUNK) | (WIDTH'(sl_sum[k]) << (WIDTH - CHUNK));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k]  <= 1'b0;
            c_q[k]  <= 1'b0;
            a_q[k]  <= '0;
            b_q[k]  <= '0;
            s_q[k]  <= '0;
            am_q[k] <= 1'b0;
            bm_q[k] <= 1'b0;
         end
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else if (en) begin
         v_q[0]  <= in_valid;
         c_q[0]  <= sub | cin;
         a_q[0]  <= a;
         b_q[0]  <= b_eff;
         s_q[0]  <= '0;
         am_q[0] <= a[WIDTH-1];
         bm_q[0] <= b_eff[WIDTH-1];
         for (int k = 1; k < STAGES; k++) begin
            v_q[k]  <= v_q[k-1];
            c_q[k]  <= sl_cout[k-1];
            a_q[k]  <= a_q[k-1] >> CHUNK;
            b_q[k]  <= b_q[k-1] >> CHUNK;
            s_q[k]  <= sum_full[k-1];
            am_q[k] <= am_q[k-1];
            bm_q[k] <= bm_q[k-1];
         end
         out_valid <= v_q[STAGES-1];
         sum       <= sum_full[STAGES-1];
         cout      <= sl_cout[STAGES-1];
         ovf       <= signed_overflow(am_q[STAGES-1], bm_q[STAGES-1],
                                      sl_sum[STAGES-1][CHUNK-1]);
      end
   end

endmodule
